// File: rtl/regfile_param_bypass_if.sv
// ============================================================================
// Module      : regfile_param_bypass_if
// Description : Bus bundle between the decode/writeback stages and the
//               integer register file. Groups the write port, both read
//               ports and the status outputs.
//                 clr      - request a full sequential clear
//                 we       - write enable
//                 waddr    - write address
//                 wbdata   - write data
//                 rs1/rs2  - read addresses
//                 rs1_data - read data, port 1 (combinational)
//                 rs2_data - read data, port 2 (combinational)
//                 busy     - clear walk in progress
//                 wr_err   - one-cycle pulse flagging a rejected write
//               master : pipeline side (drives addresses and write data)
//               slave  : register file side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_param_bypass_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [XLEN-1:0]   wbdata;
  logic [ADDR_W-1:0] rs1;
  logic [ADDR_W-1:0] rs2;
  logic [XLEN-1:0]   rs1_data;
  logic [XLEN-1:0]   rs2_data;
  logic              busy;
  logic              wr_err;

  modport master (
    output clr, we, waddr, wbdata, rs1, rs2,
    input  rs1_data, rs2_data, busy, wr_err
  );

  modport slave (
    input  clr, we, waddr, wbdata, rs1, rs2,
    output rs1_data, rs2_data, busy, wr_err
  );
endinterface

`default_nettype wire

// File: rtl/regfile_param_bypass.sv
// ============================================================================
// Module      : regfile_param_bypass
// Description : Parametrised integer register file. Two combinational read
//               ports, one synchronous write port, optional write-to-read
//               bypass, optional hardwired-zero entry 0, address range
//               checking and a sequential clear engine that zeroes one entry
//               per cycle so the storage needs no parallel reset.
//               Ports:
//                 clk   - clock, all state updates on the rising edge
//                 reset - synchronous active-high, restarts the clear walk
//                 bus   - regfile_param_bypass_if.slave (write port, read
//                         ports, busy, wr_err)
//               NREGS must satisfy 2 <= NREGS <= 2**ADDR_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_param_bypass #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  regfile_param_bypass_if.slave  bus
);

  // Storage is indexed with just enough bits for NREGS entries; the upper
  // address bits only take part in the range check.
  localparam int                IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [ADDR_W:0]   NREGS_EXT = (ADDR_W + 1)'(NREGS);
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(NREGS - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_err_q, wr_err_d;

  logic              busy;
  logic              wr_in_range;
  logic              wr_to_zero;
  logic              wr_valid;
  logic              wr_reject;

  // Single write port shared by the pipeline write and the clear walk.
  logic [XLEN-1:0]   mem [NREGS];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [XLEN-1:0]   mem_wdata;

  // --------------------------------------------------------------------------
  // Write qualification
  // --------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q == ST_CLEAR);
    wr_in_range = ({1'b0, bus.waddr} < NREGS_EXT);
    wr_to_zero  = (ZERO_REG != 0) && (bus.waddr == '0);
    wr_valid    = bus.we && !busy && wr_in_range && !wr_to_zero;
    // A write to the hardwired-zero entry is dropped without an error.
    wr_reject   = bus.we && (busy || !wr_in_range);
  end

  // --------------------------------------------------------------------------
  // Next-state / storage write decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_err_d  = wr_reject;
    mem_we    = 1'b0;
    mem_idx   = bus.waddr[IDX_W-1:0];
    mem_wdata = bus.wbdata;

    case (state_q)
      ST_IDLE: begin
        mem_we = wr_valid;
        if (bus.clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_idx   = ptr_q[IDX_W-1:0];
        mem_wdata = '0;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase

    // Reset owns the cycle: the walk restarts and no entry is written.
    if (reset) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_CLEAR;
      ptr_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      wr_err_q <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports, each resolved independently
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < 2; p++) begin : g_rd_port
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;

    assign addr = (p == 0) ? bus.rs1 : bus.rs2;

    always_comb begin
      if (busy) begin
        data = '0;
      end else if ({1'b0, addr} >= NREGS_EXT) begin
        data = '0;
      end else if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end else if ((BYPASS != 0) && wr_valid && (bus.waddr == addr)) begin
        data = bus.wbdata;
      end else begin
        data = mem[addr[IDX_W-1:0]];
      end
    end
  end

  assign bus.rs1_data = g_rd_port[0].data;
  assign bus.rs2_data = g_rd_port[1].data;
  assign bus.busy     = busy;
  assign bus.wr_err   = wr_err_q;

endmodule

`default_nettype wire
